// File: rtl/dds_pkg.sv
// Shared types for the DDS lookup-RAM arbiter: FSM states, default widths, read return tags.
package dds_pkg;

  localparam int unsigned DDS_ADDR_W = 16;
  localparam int unsigned DDS_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    LOAD  = 2'd3
  } arb_state_t;

  // One in-flight SRAM read: valid bit plus the reader it returns to.
  typedef struct packed {
    logic vld;
    logic id;
  } rd_tag_t;

endpackage

// File: rtl/arb_tag_pipe.sv
// Shift register of read tags that tracks SRAM read latency; o_empty reports no read in flight.
module arb_tag_pipe
  import dds_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic    i_clk,
  input  logic    i_rst,
  input  rd_tag_t i_tag,
  output rd_tag_t o_tag,
  output logic    o_empty
);

  rd_tag_t [DEPTH-1:0] r_pipe;
  logic                w_empty;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  always_comb begin
    w_empty = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_pipe[i].vld) w_empty = 1'b0;
    end
  end

  assign o_tag   = r_pipe[DEPTH-1];
  assign o_empty = w_empty;

endmodule

// File: rtl/dds_sram_arbiter.sv
// Shares the lookup SRAM between the flash loader and two DDS readers (load-then-run, round-robin).
// Define DDS_ARB_PERF_EN to add the rd0_stall/rd1_stall saturating stall counters.
module dds_sram_arbiter
  import dds_pkg::*;
#(
  parameter int unsigned ADDR_W   = DDS_ADDR_W,
  parameter int unsigned DATA_W   = DDS_DATA_W,
  parameter int unsigned SRAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_busy,
  input  logic              ld_wen,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  input  logic              rd0_req,
  input  logic [ADDR_W-1:0] rd0_addr,
  output logic              rd0_gnt,
  output logic              rd0_valid,
  output logic [DATA_W-1:0] rd0_data,
  input  logic              rd1_req,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic              rd1_gnt,
  output logic              rd1_valid,
  output logic [DATA_W-1:0] rd1_data,
  output logic              sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_dout,
  output logic              ready
`ifdef DDS_ARB_PERF_EN
  ,
  output logic [15:0]       rd0_stall,
  output logic [15:0]       rd1_stall
`endif
);

  arb_state_t        r_state;
  logic              r_ld_gnt;
  logic              r_ready;
  logic              r_last;
  logic              r_rd0_valid;
  logic              r_rd1_valid;
  logic [DATA_W-1:0] r_rd0_data;
  logic [DATA_W-1:0] r_rd1_data;
  logic              w_arb_en;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_pipe_empty;
  rd_tag_t           w_tag_in;
  rd_tag_t           w_tag_out;

  // Grants stop in the same cycle the loader raises ld_busy.
  assign w_arb_en = (r_state == RUN) && !ld_busy;

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (w_arb_en) begin
      if (rd0_req && rd1_req) begin
        w_gnt0 = r_last;
        w_gnt1 = !r_last;
      end else begin
        w_gnt0 = rd0_req;
        w_gnt1 = rd1_req;
      end
    end
  end

  // SRAM port is combinational so that data returns SRAM_LAT+1 cycles after the grant.
  always_comb begin
    sram_wen   = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (r_ld_gnt) begin
      sram_wen   = ld_wen;
      sram_addr  = ld_addr;
      sram_wdata = ld_wdata;
    end else if (w_gnt1) begin
      sram_addr = rd1_addr;
    end else if (w_gnt0) begin
      sram_addr = rd0_addr;
    end
  end

  assign w_tag_in.vld = w_gnt0 || w_gnt1;
  assign w_tag_in.id  = w_gnt1;

  arb_tag_pipe #(
    .DEPTH (SRAM_LAT)
  ) u_tag_pipe (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_tag   (w_tag_in),
    .o_tag   (w_tag_out),
    .o_empty (w_pipe_empty)
  );

  // An empty pipe completes DRAIN even if ld_busy already dropped, so short pulses still load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_ld_gnt <= 1'b0;
      r_ready  <= 1'b0;
    end else begin
      case (r_state)
        IDLE:  if (ld_busy) r_state <= DRAIN;
        RUN:   if (ld_busy) r_state <= DRAIN;
        DRAIN: begin
          if (w_pipe_empty) begin
            r_state  <= LOAD;
            r_ld_gnt <= 1'b1;
          end else if (!ld_busy) begin
            r_state <= r_ready ? RUN : IDLE;
          end
        end
        LOAD: begin
          if (!ld_busy) begin
            r_state  <= RUN;
            r_ld_gnt <= 1'b0;
            r_ready  <= 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last      <= 1'b0;
      r_rd0_valid <= 1'b0;
      r_rd1_valid <= 1'b0;
      r_rd0_data  <= '0;
      r_rd1_data  <= '0;
    end else begin
      if (w_gnt0 || w_gnt1) r_last <= w_gnt1;
      r_rd0_valid <= w_tag_out.vld && !w_tag_out.id;
      r_rd1_valid <= w_tag_out.vld && w_tag_out.id;
      if (w_tag_out.vld && !w_tag_out.id) r_rd0_data <= sram_dout;
      if (w_tag_out.vld && w_tag_out.id)  r_rd1_data <= sram_dout;
    end
  end

`ifdef DDS_ARB_PERF_EN
  localparam int unsigned STALL_W = 16;
  logic [STALL_W-1:0] r_rd0_stall;
  logic [STALL_W-1:0] r_rd1_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd0_stall <= '0;
      r_rd1_stall <= '0;
    end else begin
      if (rd0_req && !w_gnt0 && (r_rd0_stall != '1)) r_rd0_stall <= r_rd0_stall + STALL_W'(1);
      if (rd1_req && !w_gnt1 && (r_rd1_stall != '1)) r_rd1_stall <= r_rd1_stall + STALL_W'(1);
    end
  end

  assign rd0_stall = r_rd0_stall;
  assign rd1_stall = r_rd1_stall;
`endif

  assign ld_gnt    = r_ld_gnt;
  assign ready     = r_ready;
  assign rd0_gnt   = w_gnt0;
  assign rd1_gnt   = w_gnt1;
  assign rd0_valid = r_rd0_valid;
  assign rd1_valid = r_rd1_valid;
  assign rd0_data  = r_rd0_data;
  assign rd1_data  = r_rd1_data;

endmodule

// File: tb/tb_dds_sram_arbiter.sv
// Scoreboard bench for dds_sram_arbiter with a 1-cycle synchronous SRAM model (SRAM_LAT=1).
`timescale 1ns/1ps
module tb_dds_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_busy, ld_wen, ld_gnt;
  logic [15:0] ld_addr, ld_wdata;
  logic        rd0_req, rd0_gnt, rd0_valid;
  logic [15:0] rd0_addr, rd0_data;
  logic        rd1_req, rd1_gnt, rd1_valid;
  logic [15:0] rd1_addr, rd1_data;
  logic        sram_wen;
  logic [15:0] sram_addr, sram_wdata, sram_dout;
  logic        ready;
`ifdef DDS_ARB_PERF_EN
  logic [15:0] rd0_stall, rd1_stall;
`endif

  always #5 clk = ~clk;

  dds_sram_arbiter #(.ADDR_W(16), .DATA_W(16), .SRAM_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .ld_busy(ld_busy), .ld_wen(ld_wen), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
    .rd0_req(rd0_req), .rd0_addr(rd0_addr), .rd0_gnt(rd0_gnt), .rd0_valid(rd0_valid), .rd0_data(rd0_data),
    .rd1_req(rd1_req), .rd1_addr(rd1_addr), .rd1_gnt(rd1_gnt), .rd1_valid(rd1_valid), .rd1_data(rd1_data),
    .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_dout(sram_dout),
    .ready(ready)
`ifdef DDS_ARB_PERF_EN
    , .rd0_stall(rd0_stall), .rd1_stall(rd1_stall)
`endif
  );

  // Synchronous single-port SRAM, one cycle read latency
  logic [15:0] mem [0:255];
  int          wr_count = 0;
  always @(posedge clk) begin
    if (sram_wen) begin
      mem[sram_addr[7:0]] <= sram_wdata;
      wr_count++;
    end
    sram_dout <= mem[sram_addr[7:0]];
  end

  typedef struct {
    logic        id;
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_v0 = 0;
  int   n_v1 = 0;
  logic last_g = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Advance one clock and compare return-path outputs against the scoreboard head.
  task automatic tick();
    logic e0, e1;
    @(posedge clk);
    cyc++;
    #1;
    e0 = 1'b0;
    e1 = 1'b0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e0 = !sb[0].id;
      e1 = sb[0].id;
    end
    if (rd0_valid) n_v0++;
    if (rd1_valid) n_v1++;
    check_eq("rd0_valid", 32'(rd0_valid), 32'(e0));
    check_eq("rd1_valid", 32'(rd1_valid), 32'(e1));
    if (e0 || e1) begin
      check_eq(e0 ? "rd0_data" : "rd1_data", 32'(e0 ? rd0_data : rd1_data), 32'(sb[0].data));
      void'(sb.pop_front());
    end
  endtask

  // Drive one cycle of reader requests, check grants against the round-robin model.
  task automatic rd_cycle(input logic r0, input logic [15:0] a0, input logic r1,
                          input logic [15:0] a1, input logic run, output logic g0, output logic g1);
    logic  e0, e1;
    exp_t  t;
    rd0_req  = r0;
    rd0_addr = a0;
    rd1_req  = r1;
    rd1_addr = a1;
    #1;
    e0 = 1'b0;
    e1 = 1'b0;
    if (run) begin
      if (r0 && r1) begin
        e0 = last_g;
        e1 = !last_g;
      end else begin
        e0 = r0;
        e1 = r1;
      end
    end
    check_eq("rd0_gnt", 32'(rd0_gnt), 32'(e0));
    check_eq("rd1_gnt", 32'(rd1_gnt), 32'(e1));
    if (e0 || e1) begin
      t.id   = e1;
      t.data = ~(e1 ? a1 : a0);
      t.due  = cyc + 2;
      sb.push_back(t);
      last_g = e1;
    end
    g0 = e0;
    g1 = e1;
    tick();
  endtask

  task automatic idle(input int n, input logic run);
    logic g0, g1;
    for (int i = 0; i < n; i++) rd_cycle(1'b0, 16'd0, 1'b0, 16'd0, run, g0, g1);
  endtask

  initial begin
    logic        g0, g1;
    logic [15:0] a0, a1;
    int          base, v0b, v1b;

    rst = 1'b1;
    ld_busy = 1'b0; ld_wen = 1'b0; ld_addr = '0; ld_wdata = '0;
    rd0_req = 1'b0; rd0_addr = '0; rd1_req = 1'b0; rd1_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ld_gnt", 32'(ld_gnt), 32'd0);
    check_eq("rst_ready", 32'(ready), 32'd0);
    check_eq("rst_rd0_data", 32'(rd0_data), 32'd0);
    check_eq("rst_sram_addr", 32'(sram_addr), 32'd0);
    check_eq("rst_sram_wen", 32'(sram_wen), 32'd0);
    rst = 1'b0;

    // Readers are never granted before the first load
    rd_cycle(1'b1, 16'd3, 1'b1, 16'd4, 1'b0, g0, g1);
    idle(2, 1'b0);

    // Full 256-entry load
    ld_busy = 1'b1;
    tick();
    check_eq("drain_ld_gnt", 32'(ld_gnt), 32'd0);
    tick();
    check_eq("load_ld_gnt", 32'(ld_gnt), 32'd1);
    base = wr_count;
    for (int i = 0; i < 256; i++) begin
      ld_wen   = 1'b1;
      ld_addr  = 16'(i);
      ld_wdata = ~16'(i);
      if (i == 3) begin
        #1;
        check_eq("load_sram_wen", 32'(sram_wen), 32'd1);
        check_eq("load_sram_addr", 32'(sram_addr), 32'd3);
        check_eq("load_sram_wdata", 32'(sram_wdata), 32'hFFFC);
      end
      tick();
    end
    ld_wen  = 1'b0;
    ld_busy = 1'b0;
    #1;
    check_eq("ready_before", 32'(ready), 32'd0);
    tick();
    check_eq("ready_after", 32'(ready), 32'd1);
    check_eq("ld_gnt_released", 32'(ld_gnt), 32'd0);
    check_eq("write_count", 32'(wr_count - base), 32'd256);

    // Single read of address 5
    rd_cycle(1'b1, 16'd5, 1'b0, 16'd0, 1'b1, g0, g1);
    idle(3, 1'b1);
    check_eq("rd0_hold", 32'(rd0_data), 32'hFFFA);
    rd_cycle(1'b0, 16'd0, 1'b1, 16'd9, 1'b1, g0, g1);
    idle(3, 1'b1);

    // Both readers held for 8 cycles: alternating grants
    a0 = 16'd16;
    a1 = 16'd32;
    v0b = n_v0;
    v1b = n_v1;
    for (int k = 0; k < 8; k++) begin
      rd_cycle(1'b1, a0, 1'b1, a1, 1'b1, g0, g1);
      if (g0) a0++;
      if (g1) a1++;
    end
    idle(3, 1'b1);
    check_eq("rr_valids0", 32'(n_v0 - v0b), 32'd4);
    check_eq("rr_valids1", 32'(n_v1 - v1b), 32'd4);

    // Load request while a read is in flight; early ld_wen must not write
    rd_cycle(1'b1, 16'd40, 1'b0, 16'd0, 1'b1, g0, g1);
    base     = wr_count;
    ld_busy  = 1'b1;
    ld_wen   = 1'b1;
    ld_addr  = 16'd5;
    ld_wdata = 16'h1234;
    rd_cycle(1'b0, 16'd0, 1'b1, 16'd41, 1'b0, g0, g1);
    check_eq("drain_ld_gnt2", 32'(ld_gnt), 32'd0);
    check_eq("drain_sram_wen", 32'(sram_wen), 32'd0);
    ld_wen = 1'b0;
    rd_cycle(1'b0, 16'd0, 1'b1, 16'd41, 1'b0, g0, g1);
    check_eq("load_ld_gnt2", 32'(ld_gnt), 32'd1);
    check_eq("no_early_write", 32'(wr_count - base), 32'd0);
    ld_busy = 1'b0;
    rd_cycle(1'b0, 16'd0, 1'b1, 16'd41, 1'b0, g0, g1);
    rd_cycle(1'b0, 16'd0, 1'b1, 16'd41, 1'b1, g0, g1);
    rd_cycle(1'b1, 16'd5, 1'b0, 16'd0, 1'b1, g0, g1);
    idle(3, 1'b1);

    // Reset with a read in flight: the pending valid is discarded
    rd_cycle(1'b1, 16'd7, 1'b0, 16'd0, 1'b1, g0, g1);
    rst = 1'b1;
    sb.delete();
    #1;
    check_eq("rstrd_ready", 32'(ready), 32'd0);
    check_eq("rstrd_gnt", 32'(rd0_gnt), 32'd0);
    rd0_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    idle(2, 1'b0);

    // Reset in the middle of a load
    ld_busy = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      ld_wen   = 1'b1;
      ld_addr  = 16'(i);
      ld_wdata = ~16'(i);
      tick();
    end
    rst = 1'b1;
    #1;
    check_eq("rstld_ld_gnt", 32'(ld_gnt), 32'd0);
    check_eq("rstld_sram_wen", 32'(sram_wen), 32'd0);
    ld_wen  = 1'b0;
    ld_busy = 1'b0;
    tick();
    check_eq("rstld_ready", 32'(ready), 32'd0);
    check_eq("rstld_sram_addr", 32'(sram_addr), 32'd0);
    rst = 1'b0;
    idle(2, 1'b0);

`ifdef DDS_ARB_PERF_EN
    // rd1 blocked for 3 cycles (no grants before a load), then saturation of rd0_stall
    for (int i = 0; i < 3; i++) rd_cycle(1'b0, 16'd0, 1'b1, 16'd0, 1'b0, g0, g1);
    rd1_req = 1'b0;
    #1;
    check_eq("rd1_stall", 32'(rd1_stall), 32'd3);
    check_eq("rd0_stall_zero", 32'(rd0_stall), 32'd0);
    rd0_req = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    check_eq("rd0_stall_sat", 32'(rd0_stall), 32'hFFFF);
    repeat (4) @(posedge clk);
    #1;
    check_eq("rd0_stall_hold", 32'(rd0_stall), 32'hFFFF);
    rd0_req = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
